// File: rtl/hex_anim_pkg.sv
// hex_anim_pkg: shared leg encoding (equals row_o) and default display count for the circle animation
package hex_anim_pkg;
  typedef enum logic {REV = 1'b0, FWD = 1'b1} leg_e;
  localparam int DEFAULT_DISPLAY_COUNT = 6;
endpackage

// File: rtl/hex_circle_sequencer_if.sv
// hex_circle_sequencer_if: control in (en_i, rev_i, step_i), position out (row_o, col_o, step_o, lap_o)
interface hex_circle_sequencer_if
  import hex_anim_pkg::*;
#(
  parameter int COL_WIDTH = $clog2(DEFAULT_DISPLAY_COUNT)
);
  logic                 en_i;
  logic                 rev_i;
  logic                 step_i;
  logic                 row_o;
  logic [COL_WIDTH-1:0] col_o;
  logic                 step_o;
  logic                 lap_o;
  modport master (output en_i, rev_i, step_i, input row_o, col_o, step_o, lap_o);
  modport slave  (input en_i, rev_i, step_i, output row_o, col_o, step_o, lap_o);
endinterface

// File: rtl/hex_circle_sequencer_tick_prescaler.sv
// tick_prescaler: clk_i/rst_i, en_i counts 0..TICK_DIV-1, clr_i restarts at 0, tick_o high on terminal count
module tick_prescaler #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int DIV_WIDTH = $clog2(TICK_DIV + 1);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = en_i && cnt_q == DIV_WIDTH'(TICK_DIV - 1);
    cnt_d  = (clr_i || tick_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    cnt_q <= rst_i ? '0 : cnt_d;
  end
endmodule

// File: rtl/hex_circle_sequencer.sv
// hex_circle_sequencer: clk_i/rst_i plus slave bus; walks (row_o,col_o) around a 2*DISPLAY_COUNT loop with step_o/lap_o pulses
module hex_circle_sequencer
  import hex_anim_pkg::*;
#(
  parameter int DISPLAY_COUNT = DEFAULT_DISPLAY_COUNT,
  parameter int TICK_DIV      = 12_500_000
) (
  input logic                   clk_i,
  input logic                   rst_i,
  hex_circle_sequencer_if.slave bus
);
  localparam int COL_WIDTH = $clog2(DISPLAY_COUNT);
  localparam logic [0:0] ST_FWD = FWD;
  logic [0:0]           state_q, state_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic                 step_q, lap_q;
  logic                 tick, ev, inc, edge_hit;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (bus.en_i),
    .clr_i  (bus.step_i),
    .tick_o (tick)
  );
  // inc: column moves up (clockwise on top leg, counter-clockwise on bottom leg)
  always_comb begin
    ev       = tick || bus.step_i;
    inc      = (state_q == ST_FWD) ^ bus.rev_i;
    edge_hit = inc ? col_q == COL_WIDTH'(DISPLAY_COUNT - 1) : col_q == '0;
    state_d  = (ev && edge_hit) ? ~state_q : state_q;
    col_d    = (!ev || edge_hit) ? col_q : inc ? col_q + 1'b1 : col_q - 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FWD;
      col_q   <= '0;
      step_q  <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      step_q  <= ev;
      lap_q   <= ev && state_d == ST_FWD && col_d == '0;
    end
  end
  assign bus.row_o  = state_q;
  assign bus.col_o  = col_q;
  assign bus.step_o = step_q;
  assign bus.lap_o  = lap_q;
endmodule

// File: tb/tb_hex_circle_sequencer.sv
// tb_hex_circle_sequencer: directed plus random stimulus checked against a loop-index reference model
module tb_hex_circle_sequencer;
  localparam int N  = 6;
  localparam int TD = 4;
  localparam int CW = $clog2(N);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hex_circle_sequencer_if #(.COL_WIDTH(CW)) bus ();
  hex_circle_sequencer #(.DISPLAY_COUNT(N), .TICK_DIV(TD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );
  int checks = 0;
  int errors = 0;
  int p = 0;
  int cnt = 0;
  int obs_steps = 0;
  int obs_laps = 0;
  logic e_step = 1'b0;
  logic e_lap = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_pos(input string tag, input int r, input int c);
    chk({tag, "_row"}, 32'(bus.row_o), 32'(r));
    chk({tag, "_col"}, 32'(bus.col_o), 32'(c));
  endtask
  task automatic cyc(input logic r, input logic en, input logic rv, input logic st);
    logic tick;
    rst = r;
    bus.en_i = en;
    bus.rev_i = rv;
    bus.step_i = st;
    @(posedge clk);
    if (r) begin
      p = 0;
      cnt = 0;
      e_step = 1'b0;
      e_lap = 1'b0;
    end else begin
      tick = en && cnt == TD - 1;
      e_step = tick || st;
      cnt = (st || tick) ? 0 : en ? cnt + 1 : cnt;
      if (e_step) p = rv ? (p + 2 * N - 1) % (2 * N) : (p + 1) % (2 * N);
      e_lap = e_step && p == 0;
    end
    #1;
    chk("row", 32'(bus.row_o), 32'(p < N));
    chk("col", 32'(bus.col_o), 32'(p < N ? p : 2 * N - 1 - p));
    chk("step", 32'(bus.step_o), 32'(e_step));
    chk("lap", 32'(bus.lap_o), 32'(e_lap));
    if (bus.step_o === 1'b1) obs_steps++;
    if (bus.lap_o === 1'b1) obs_laps++;
  endtask
  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    obs_steps = 0;
    obs_laps = 0;
  endtask
  initial begin
    bus.en_i = 1'b0;
    bus.rev_i = 1'b0;
    bus.step_i = 1'b0;
    do_reset();
    chk_pos("reset", 1, 0);
    chk("reset_step", 32'(bus.step_o), 0);
    chk("reset_lap", 32'(bus.lap_o), 0);
    for (int i = 0; i < 48; i++) cyc(0, 1, 0, 0);
    chk("cw_steps", 32'(obs_steps), 12);
    chk("cw_laps", 32'(obs_laps), 1);
    chk_pos("cw_home", 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0);
    chk_pos("ccw_first", 0, 0);
    for (int i = 0; i < 44; i++) cyc(0, 1, 1, 0);
    chk("ccw_steps", 32'(obs_steps), 12);
    chk("ccw_laps", 32'(obs_laps), 1);
    chk_pos("ccw_home", 1, 0);
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 0, 1);
      chk_pos("manual", 1, k);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    end
    chk("manual_steps", 32'(obs_steps), 3);
    obs_steps = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("tick_and_step", 32'(obs_steps), 1);
    chk_pos("tick_and_step", 1, 4);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("after_coincide_quiet", 32'(obs_steps), 1);
    cyc(0, 1, 0, 0);
    chk_pos("after_coincide_auto", 1, 5);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk_pos("flip_start", 1, 4);
    cyc(0, 0, 1, 1);
    chk_pos("flip_rev", 1, 3);
    cyc(0, 0, 0, 1);
    chk_pos("flip_back", 1, 4);
    do_reset();
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1);
    chk_pos("pre_rst", 0, 2);
    cyc(1, 0, 0, 1);
    chk_pos("mid_rst", 1, 0);
    chk("mid_rst_step", 32'(bus.step_o), 0);
    chk("mid_rst_lap", 32'(bus.lap_o), 0);
    obs_steps = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("rst_release_quiet", 32'(obs_steps), 0);
    cyc(0, 1, 0, 0);
    chk_pos("rst_release_auto", 1, 1);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hex_circle_sequencer.md
Name: hex_circle_sequencer

Overview:
- Generates the moving-segment position that drives the 6-display 7-segment "circle" animation.
- Produces the row/column pair consumed by the display-side deplasare driver:
  - row_o=1 means top segment (forward leg); row_o=0 means bottom segment (return leg).
  - col_o selects the active display.
- Steps around a closed loop of 2*DISPLAY_COUNT positions at a prescaled rate. Supports pause, reversal and manual single-step.
- Sits between the board clock/switch logic and the display driver on the DE10-Lite top level.

Parameters:
- DISPLAY_COUNT, 6, number of 7-segment displays in the loop; legal range >= 2.
- TICK_DIV, 12_500_000, clock cycles per automatic step (4 Hz at 50 MHz); legal range >= 1.
- COL_WIDTH, $clog2(DISPLAY_COUNT), width of col_o.
- DIV_WIDTH, $clog2(TICK_DIV+1), prescaler counter width.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  1 = automatic stepping runs; 0 = prescaler and position hold.
- rev_i  input  1  traversal sense, sampled on every step: 0 = clockwise, 1 = counter-clockwise.
- step_i  input  1  single-cycle pulse; forces one immediate step regardless of en_i.
- row_o  output  1  current leg: 1 = top/forward, 0 = bottom/return.
- col_o  output  COL_WIDTH  current display index, 0..DISPLAY_COUNT-1.
- step_o  output  1  one-cycle pulse, high in the first cycle a new position is valid.
- lap_o  output  1  one-cycle pulse, coincident with step_o, when the new position is home (row 1, col 0).

Behaviour:
- All outputs are registered. Reset is synchronous and active-high; it dominates every other input in the same cycle.
- Reset values: row_o=1, col_o=0, step_o=0, lap_o=0; prescaler=0; state=FWD.
- FSM states:
  - FWD (row_o=1).
  - REV (row_o=0).
  - row_o is decoded directly from the state register.
- Prescaler:
  - When en_i=1, counts 0..TICK_DIV-1. At TICK_DIV-1 it raises an internal tick and wraps to 0.
  - When en_i=0, it holds its value.
  - When TICK_DIV=1, a tick occurs every cycle while en_i=1.
- Step event = tick OR step_i.
  - step_i clears the prescaler to 0.
  - Tick and step_i in the same cycle produce exactly one step.
- Clockwise step (rev_i=0):
  - FWD col k<N-1 -> FWD col k+1.
  - FWD col N-1 -> REV col N-1.
  - REV col k>0 -> REV col k-1.
  - REV col 0 -> FWD col 0.
- Counter-clockwise step (rev_i=1): the exact inverse of the clockwise map.
  - FWD col k>0 -> FWD col k-1.
  - FWD col 0 -> REV col 0.
  - REV col k<N-1 -> REV col k+1.
  - REV col N-1 -> FWD col N-1.
- Latency: the new position, step_o and lap_o appear on the clock edge that samples the step event (1-cycle latency from step_i).
- Changing rev_i mid-loop is legal. It takes effect at the next step, and the position never skips.
- col_o never leaves 0..DISPLAY_COUNT-1, including when DISPLAY_COUNT is not a power of two. Wrap decisions compare against DISPLAY_COUNT-1, never against 2**COL_WIDTH-1.
- step_o and lap_o are 0 in every cycle without a step.
- lap_o fires on any step whose destination is (FWD, 0), in either direction.
- Full loop = 2*DISPLAY_COUNT steps; lap_o fires exactly once per loop.
- Reset mid-operation:
  - Position returns to home and the prescaler clears.
  - No step_o or lap_o is generated for the reset itself.
  - Pending step_i in the reset cycle is discarded.

Decomposition:
- Package hex_anim_pkg holds:
  - typedef enum logic {REV=1'b0, FWD=1'b1} leg_e, so the encoding equals row_o directly.
  - Localparam DEFAULT_DISPLAY_COUNT=6, shared with the display-side driver.
- One sub-module, tick_prescaler:
  - Parameter TICK_DIV; inputs clk_i, rst_i, en_i, clr_i; output tick_o.
  - Reusable for the LED-chase sequencer.
- The FSM and column counter stay in the top module.

Test Plan:
- Reset, then DISPLAY_COUNT=6, TICK_DIV=4, en_i=1, rev_i=0 held 48 cycles -> 12 step_o pulses, spaced 4 cycles apart.
  - (row,col) sequence (1,0)->(1,1)..(1,5)->(0,5)..(0,0)->(1,0).
  - lap_o exactly once, on the 12th step.
- Same setup with rev_i=1 from reset -> first step gives (0,0), then (0,1)..(0,5),(1,5)..(1,1),(1,0).
  - lap_o on the 12th step.
- en_i=0, step_i pulsed 3 times, 5 cycles apart -> each pulse moves one position after 1 cycle: (1,1),(1,2),(1,3).
  - Prescaler does not advance.
- Prescaler terminal count (en_i=1) coincides with step_i -> exactly one step; next auto step 4 cycles later.
- At (1,4), flip rev_i to 1 for one step, then back to 0 -> positions (1,3) then (1,4); no skipped or duplicated index.
- rst_i asserted at (0,2) together with step_i -> next cycle (1,0), step_o=0, lap_o=0, prescaler=0.
  - First auto step occurs TICK_DIV cycles after reset release.
